// File: rtl/trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trace_sequencer
// Brief    : Per-frame trace pass controller. It opens a pass in VBLANK, keeps
//            the view vectors steady, takes host updates and times each pass.
// Revision : 1.0
// ============================================================================
module trace_sequencer #(
    parameter int            FW         = 16,
    parameter int            CW         = 16,
    parameter int            START_LINE = 480,
    parameter int            END_LINE   = 524,
    parameter int            LAST_COL   = 639,
    parameter logic [FW-1:0] DEF_PX     = 16'h0600,
    parameter logic [FW-1:0] DEF_PY     = 16'h0600,
    parameter logic [FW-1:0] DEF_FX     = 16'h0000,
    parameter logic [FW-1:0] DEF_FY     = 16'hFC00,
    parameter logic [FW-1:0] DEF_VX     = 16'h0200,
    parameter logic [FW-1:0] DEF_VY     = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    hpos_i,
    input  logic [9:0]    vpos_i,
    input  logic          host_valid_i,
    output logic          host_ready_o,
    input  logic [FW-1:0] host_px_i,
    input  logic [FW-1:0] host_py_i,
    input  logic [FW-1:0] host_fx_i,
    input  logic [FW-1:0] host_fy_i,
    input  logic [FW-1:0] host_vx_i,
    input  logic [FW-1:0] host_vy_i,
    input  logic          trace_store_i,
    input  logic [9:0]    trace_column_i,
    output logic          tracer_enable_o,
    output logic [FW-1:0] act_px_o,
    output logic [FW-1:0] act_py_o,
    output logic [FW-1:0] act_fx_o,
    output logic [FW-1:0] act_fy_o,
    output logic [FW-1:0] act_vx_o,
    output logic [FW-1:0] act_vy_o,
    output logic [10:0]   frame_count_o,
    output logic          busy_o,
    output logic          done_pulse_o,
    output logic          overrun_pulse_o,
    output logic          overrun_flag_o,
    output logic [CW-1:0] last_cycles_o
);

    localparam int              VW         = 6 * FW;
    localparam logic [9:0]      C_START    = 10'(START_LINE);
    localparam logic [9:0]      C_END      = 10'(END_LINE);
    localparam logic [9:0]      C_LAST_COL = 10'(LAST_COL);
    localparam logic [VW-1:0]   C_DEF_VIEW = {DEF_PX, DEF_PY, DEF_FX, DEF_FY, DEF_VX, DEF_VY};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            enable_q, enable_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cycles_q, cycles_d;
    logic [CW-1:0]   last_q, last_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;
    logic            flag_q, flag_d;
    logic [10:0]     frame_q, frame_d;
    logic [VW-1:0]   act_q, act_d;
    logic [VW-1:0]   pend_q, pend_d;
    logic            pend_empty_q, pend_empty_d;

    logic            w_in_win;
    logic            w_start_pos;
    logic            w_last_store;
    logic            w_host_accept;
    logic [CW-1:0]   w_cycles_inc;
    logic [VW-1:0]   w_host_view;

    assign w_in_win      = (vpos_i >= C_START) && (vpos_i <= C_END);
    assign w_start_pos   = (hpos_i == 10'd0) && (vpos_i == C_START);
    assign w_last_store  = trace_store_i && (trace_column_i == C_LAST_COL);
    assign w_host_accept = host_valid_i && pend_empty_q;
    assign w_cycles_inc  = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
    assign w_host_view   = {host_px_i, host_py_i, host_fx_i, host_fy_i, host_vx_i, host_vy_i};

    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        busy_d       = busy_q;
        cycles_d     = cycles_q;
        last_d       = last_q;
        done_d       = 1'b0;
        ovr_d        = 1'b0;
        flag_d       = flag_q;
        frame_d      = frame_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_empty_d = pend_empty_q;

        // Accept is gated by the pre-cycle empty flag, so a beat landing on
        // the start cycle stays pending rather than entering this pass.
        if (w_host_accept) begin
            pend_d       = w_host_view;
            pend_empty_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_start_pos) begin
                    state_d  = S_TRACING;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    cycles_d = '0;
                    frame_d  = frame_q + 11'd1;
                    if (!pend_empty_q) begin
                        act_d        = pend_q;
                        pend_empty_d = 1'b1;
                    end
                end
            end
            S_TRACING: begin
                cycles_d = w_cycles_inc;
                // The pass length includes the cycle that ends it.
                if (w_last_store) begin
                    last_d   = w_cycles_inc;
                    done_d   = 1'b1;
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else if (!w_in_win) begin
                    last_d   = w_cycles_inc;
                    ovr_d    = 1'b1;
                    flag_d   = 1'b1;
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_DONE: begin
                if (!w_in_win) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            cycles_q     <= '0;
            last_q       <= '0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            flag_q       <= 1'b0;
            frame_q      <= '0;
            act_q        <= C_DEF_VIEW;
            pend_q       <= '0;
            pend_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            cycles_q     <= cycles_d;
            last_q       <= last_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            flag_q       <= flag_d;
            frame_q      <= frame_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_empty_q <= pend_empty_d;
        end
    end

    assign host_ready_o    = pend_empty_q;
    assign tracer_enable_o = enable_q;
    assign busy_o          = busy_q;
    assign done_pulse_o    = done_q;
    assign overrun_pulse_o = ovr_q;
    assign overrun_flag_o  = flag_q;
    assign frame_count_o   = frame_q;
    assign last_cycles_o   = last_q;
    assign {act_px_o, act_py_o, act_fx_o, act_fy_o, act_vx_o, act_vy_o} = act_q;

endmodule
`default_nettype wire
